loba_mult_pipe: RTL
===================

# loba_mult_pipe

Pipelined, parameterised signed multiplier based on leading-one bit approximation (LOBA). The number of partial products (1–4) is selectable per operation and carried through the pipeline with each operand pair. The block uses a valid/ready handshake on both sides. It is the sequential, throughput-oriented version of the team's combinational LOBA multipliers, for use in streaming datapaths of approximate-computing designs.

## Interface
Parameters:
- `K`, 4: width of each truncated operand segment; must satisfy 2 ≤ K ≤ min(NA, NB).
- `NA`, 16: width of operand A (two's complement).
- `NB`, 16: width of operand B (two's complement).

Ports:
- `clk` input, 1: single clock; all state is updated on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operand pair is present.
- `in_ready` output, 1: the block accepts the pair on this cycle.
- `in_a` input, NA: signed operand A.
- `in_b` input, NB: signed operand B.
- `in_mode` input, 2: number of partial products minus 1.
  - 0 = Ah·Bh
  - 1 = adds Ah·Bl
  - 2 = adds Al·Bh
  - 3 = adds Al·Bl
- `out_valid` output, 1: result is present.
- `out_ready` input, 1: downstream accepts the result.
- `out_r` output, NA+NB: signed product.

## Operation
- **Sign handling.**
  - |a| = a[NA-1] ? ~a+1 : a, interpreted as NA-bit unsigned; the most-negative value maps to 2^(NA-1). |b| is formed the same way.
  - Output sign = a[NA-1] ^ b[NB-1].
  - The final result is negated in two's complement when the sign is set. A zero magnitude yields 0 regardless of sign.
- **Split**, for each unsigned magnitude X of width N:
  - kh = position of the leading one, clamped to ≥ K-1 (X=0 gives kh = K-1).
  - Xh = X[kh -: K].
  - rem = X with bits [N-1 : kh-K+1] cleared.
  - kl = leading-one position of rem, clamped to ≥ K-1.
  - Xl = rem[kl -: K].
- **Partial products** (unsigned, each 2K bits, all shifts non-negative):
  - PP_hh = (Ah·Bh) << (kh_a + kh_b − 2(K−1))
  - PP_hl = (Ah·Bl) << (kh_a + kl_b − 2(K−1))
  - PP_lh = (Al·Bh) << (kl_a + kh_b − 2(K−1))
  - PP_ll = (Al·Bl) << (kl_a + kl_b − 2(K−1))
- **Sum.**
  - Sum = PP_hh + (mode ≥ 1 ? PP_hl : 0) + (mode ≥ 2 ? PP_lh : 0) + (mode = 3 ? PP_ll : 0).
  - Accumulated at NA+NB+1 bits, truncated to NA+NB bits before sign restore.
- **Exactness.** Operands with |x| < 2^K are exact in every mode. Mode 3 is exact whenever each magnitude fits in two K-bit segments.
- **Mode capture.** `in_mode` is captured with the operands. Mixed modes in flight are each processed according to their own captured mode.

## Timing
- **Pipeline stages.**
  - S1: abs + split.
  - S2: four partial products + shifts.
  - S3: sum + sign restore into the `out_r` register.
- **Latency.** Exactly 3 cycles from an accepted input to `out_valid`, with no stall. Throughput is 1 result per cycle.
- **Advance condition.** adv = !out_valid | out_ready. `in_ready` = adv, driven combinationally from `out_valid`/`out_ready` only.
- **Stall.** When !adv, all stage registers hold, and `out_r`/`out_valid` remain stable until the handshake completes.
- **Pipeline bubbles.** Each stage carries its own valid bit. Invalid stages still advance when adv = 1; bubbles do not compress.
- **Simultaneous events.** When `out_valid & out_ready & in_valid`, the output is consumed and a new pair is accepted in the same cycle.
- **Reset values.** Asynchronous assertion of `rst_n` clears all stage valid bits, sets `out_valid` = 0 and `out_r` = 0, and sets `in_ready` = 1 in the next evaluation.
- **Reset mid-operation.** In-flight data is discarded; no partial result is emitted after release.
- **Reset release.** The first acceptance occurs on the first rising edge with `rst_n` = 1.

## Structure
- **Package `loba_pkg`:**
  - mode enum: LOBA_HH, LOBA_HL, LOBA_HLLH, LOBA_ALL
  - function `clog2`-sized width constants
  - leading-one-clamped function `lob_pos(x, K)`
- **Sub-module `loba_operand_split`** (combinational, parameters `K`, `N`): X → {Xh, Xl, kh, kl}. It is instantiated twice in S1.

## Test plan
All scenarios use K=4, NA=NB=16.
- **Modes 0/1/2.** a=100, b=3, mode 0 → 288; mode 1 → 288; mode 2 → 300; mode 3 → 300, each after exactly 3 cycles.
- **Sign handling.** a=−100, b=3, mode 2 → `out_r` = 0xFFFFFED4 (−300); a=−5, b=−7, mode 0 → 35; a=0, b=−9 → 0.
- **Extremes.** a=−32768, b=1, mode 3 → 0xFFFF8000; a=32767, b=32767, mode 0 → (15·15)<<22 = 0x38400000.
- **Back-to-back with mixed modes.** The same operand pair is driven with modes 0,1,2,3 on consecutive cycles with `out_ready` = 1 → results appear in order on 4 consecutive cycles.
- **Backpressure.** `out_ready` = 0 for 5 cycles with the pipeline full → `in_ready` = 0, `out_r` is stable, and no result is lost or duplicated after release.
- **Mid-stream reset.** `rst_n` is pulsed low with 3 items in flight → `out_valid` drops immediately, `out_r` = 0, and no stale result appears after release.

Source files
------------

// File: rtl/loba_pkg.sv
// Shared types and helpers for the pipelined LOBA multiplier.
package loba_pkg;

   typedef enum logic [1:0] {
      LOBA_HH   = 2'd0,
      LOBA_HL   = 2'd1,
      LOBA_HLLH = 2'd2,
      LOBA_ALL  = 2'd3
   } loba_mode_e;

   localparam int LOBA_MAX_W = 64;

   // Width needed to hold a bit position inside an n-bit operand.
   function automatic int pos_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Leading-one position, never below k-1 so a K-bit window always fits.
   function automatic int lob_pos(input logic [LOBA_MAX_W-1:0] x, input int k);
      int p;
      p = k - 1;
      for (int i = 0; i < LOBA_MAX_W; i++) begin
         if (x[i] && (i > p)) p = i;
      end
      return p;
   endfunction

endpackage

// File: rtl/loba_operand_split.sv
// Splits an unsigned magnitude into high and low K-bit leading-one segments.
module loba_operand_split
   import loba_pkg::*;
#(
   parameter int K = 4,
   parameter int N = 16
) (
   input  logic [N-1:0]          x,
   output logic [K-1:0]          xh,
   output logic [K-1:0]          xl,
   output logic [pos_w(N)-1:0]   kh,
   output logic [pos_w(N)-1:0]   kl
);

   localparam int PW = pos_w(N);

   int          kh_i;
   int          kl_i;
   logic [N-1:0] xh_w;
   logic [N-1:0] rem;
   logic [N-1:0] xl_w;

   always_comb begin
      kh_i = lob_pos(LOBA_MAX_W'(x), K);
      xh_w = x >> (kh_i - K + 1);
      // rem keeps only the bits below the high window
      rem  = x & ~({N{1'b1}} << (kh_i - K + 1));
      kl_i = lob_pos(LOBA_MAX_W'(rem), K);
      xl_w = rem >> (kl_i - K + 1);
      xh   = xh_w[K-1:0];
      xl   = xl_w[K-1:0];
      kh   = PW'(kh_i);
      kl   = PW'(kl_i);
   end

endmodule

// File: rtl/loba_mult_pipe.sv
// Three-stage signed LOBA multiplier with per-item partial-product count
// and valid/ready handshakes on both sides.
module loba_mult_pipe
   import loba_pkg::*;
#(
   parameter int K  = 4,
   parameter int NA = 16,
   parameter int NB = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NA-1:0]     in_a,
   input  logic [NB-1:0]     in_b,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NA+NB-1:0]  out_r
);

   localparam int NR = NA + NB;
   localparam int PA = pos_w(NA);
   localparam int PB = pos_w(NB);

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic [NA-1:0] a_mag;
   logic [NB-1:0] b_mag;
   logic [K-1:0]  ah0, al0, bh0, bl0;
   logic [PA-1:0] kha0, kla0;
   logic [PB-1:0] khb0, klb0;

   always_comb begin
      a_mag = in_a[NA-1] ? (~in_a + 1'b1) : in_a;
      b_mag = in_b[NB-1] ? (~in_b + 1'b1) : in_b;
   end

   loba_operand_split #(.K(K), .N(NA)) u_split_a (
      .x(a_mag), .xh(ah0), .xl(al0), .kh(kha0), .kl(kla0)
   );

   loba_operand_split #(.K(K), .N(NB)) u_split_b (
      .x(b_mag), .xh(bh0), .xl(bl0), .kh(khb0), .kl(klb0)
   );

   logic          v1, sign1;
   loba_mode_e    mode1;
   logic [K-1:0]  ah1, al1, bh1, bl1;
   logic [PA-1:0] kha1, kla1;
   logic [PB-1:0] khb1, klb1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         sign1 <= 1'b0;
         mode1 <= LOBA_HH;
         ah1   <= '0;
         al1   <= '0;
         bh1   <= '0;
         bl1   <= '0;
         kha1  <= '0;
         kla1  <= '0;
         khb1  <= '0;
         klb1  <= '0;
      end else if (adv) begin
         v1    <= in_valid;
         sign1 <= in_a[NA-1] ^ in_b[NB-1];
         mode1 <= loba_mode_e'(in_mode);
         ah1   <= ah0;
         al1   <= al0;
         bh1   <= bh0;
         bl1   <= bl0;
         kha1  <= kha0;
         kla1  <= kla0;
         khb1  <= khb0;
         klb1  <= klb0;
      end
   end

   // Shift is the sum of both window LSB positions, always >= 0.
   function automatic logic [NR-1:0] pp(input logic [K-1:0] x, input logic [K-1:0] y,
                                        input int kx, input int ky);
      logic [2*K-1:0] m;
      m = {{K{1'b0}}, x} * {{K{1'b0}}, y};
      return NR'(m) << (kx + ky - 2 * (K - 1));
   endfunction

   logic          v2, sign2;
   loba_mode_e    mode2;
   logic [NR-1:0] pp_hh2, pp_hl2, pp_lh2, pp_ll2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2     <= 1'b0;
         sign2  <= 1'b0;
         mode2  <= LOBA_HH;
         pp_hh2 <= '0;
         pp_hl2 <= '0;
         pp_lh2 <= '0;
         pp_ll2 <= '0;
      end else if (adv) begin
         v2     <= v1;
         sign2  <= sign1;
         mode2  <= mode1;
         pp_hh2 <= pp(ah1, bh1, int'(kha1), int'(khb1));
         pp_hl2 <= pp(ah1, bl1, int'(kha1), int'(klb1));
         pp_lh2 <= pp(al1, bh1, int'(kla1), int'(khb1));
         pp_ll2 <= pp(al1, bl1, int'(kla1), int'(klb1));
      end
   end

   logic [NR:0]   sum;
   logic [NR-1:0] mag3;
   logic [NR-1:0] res3;

   always_comb begin
      sum = {1'b0, pp_hh2};
      if (mode2 >= LOBA_HL)   sum = sum + {1'b0, pp_hl2};
      if (mode2 >= LOBA_HLLH) sum = sum + {1'b0, pp_lh2};
      if (mode2 == LOBA_ALL)  sum = sum + {1'b0, pp_ll2};
      mag3 = sum[NR-1:0];
      res3 = sign2 ? (~mag3 + 1'b1) : mag3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_r     <= '0;
      end else if (adv) begin
         out_valid <= v2;
         out_r     <= res3;
      end
   end

endmodule
